// File: rtl/ws2812b_strip_driver.sv
// WS2812B strip driver: byte-register colour buffer serialised MSB-first onto uo_out[OUT_BIT].
// Register reads are combinational; START reaches the pin one cycle later; DATA writes while busy are dropped and flag ERR.
module ws2812b_strip_driver #(
  parameter int NUM_LEDS   = 4,
  parameter int T0H        = 26,
  parameter int T1H        = 51,
  parameter int TBIT       = 80,
  parameter int RES_CYCLES = 3200,
  parameter int OUT_BIT    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int NBYTES = 3 * NUM_LEDS;
  localparam int NBITS  = 24 * NUM_LEDS;
  localparam int PW     = $clog2(NBYTES);
  localparam int BW     = $clog2(NBITS);
  localparam int CW     = $clog2(TBIT);
  localparam int LW     = $clog2(RES_CYCLES);

  if (!(T0H > 0 && T0H < T1H && T1H < TBIT)) begin : g_bad_timing
    $error("ws2812b_strip_driver: need 0 < T0H < T1H < TBIT");
  end
  if (OUT_BIT < 1 || OUT_BIT > 7 || RES_CYCLES < 2 || NBYTES > 255) begin : g_bad_cfg
    $error("ws2812b_strip_driver: illegal OUT_BIT, RES_CYCLES or NUM_LEDS");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_LATCH
  } state_t;

  state_t          r_state;
  logic [7:0]      r_buf [NBYTES];
  logic [PW-1:0]   r_ptr;
  logic [BW-1:0]   r_bit_idx;
  logic [CW-1:0]   r_cyc;
  logic [LW-1:0]   r_lat;
  logic            r_bit;
  logic            r_dout;
  logic            r_done;
  logic            r_repeat;
  logic            r_err;

  logic            w_busy;
  logic            w_wr_ctrl;
  logic            w_wr_ptr;
  logic            w_wr_data;
  logic            w_start;
  logic            w_repeat_nxt;
  logic            w_last_cyc;
  logic            w_last_bit;
  logic            w_last_lat;
  logic [BW-1:0]   w_nxt_idx;
  logic [PW-1:0]   w_nxt_byte;
  logic [2:0]      w_nxt_bpos;
  logic            w_nxt_bit;
  logic [CW-1:0]   w_cyc_nxt;
  logic [CW-1:0]   w_thigh;
  logic            w_high_nxt;

  assign w_busy       = (r_state != S_IDLE);
  assign w_wr_ctrl    = data_write && (address == 4'h0);
  assign w_wr_ptr     = data_write && (address == 4'h1);
  assign w_wr_data    = data_write && (address == 4'h2);
  assign w_start      = w_wr_ctrl && data_in[0] && !w_busy;
  assign w_repeat_nxt = w_wr_ctrl ? data_in[2] : r_repeat;

  assign w_last_cyc   = (r_cyc == CW'(TBIT - 1));
  assign w_last_bit   = (r_bit_idx == BW'(NBITS - 1));
  assign w_last_lat   = (r_lat == LW'(RES_CYCLES - 1));

  // Bit n of the frame is bit (7 - n%8) of byte n/8; 7-x is ~x in three bits.
  assign w_nxt_idx    = r_bit_idx + 1'b1;
  assign w_nxt_byte   = w_nxt_idx[BW-1:3];
  assign w_nxt_bpos   = ~w_nxt_idx[2:0];
  assign w_nxt_bit    = r_buf[w_nxt_byte][w_nxt_bpos];

  assign w_cyc_nxt    = r_cyc + 1'b1;
  assign w_thigh      = r_bit ? CW'(T1H) : CW'(T0H);
  assign w_high_nxt   = (w_cyc_nxt < w_thigh);

  always_comb begin
    uo_out          = 8'h00;
    uo_out[OUT_BIT] = r_dout;
  end

  always_comb begin
    case (address)
      4'h0:    data_out = {4'b0000, r_err, r_repeat, r_done, w_busy};
      4'h1:    data_out = 8'(r_ptr);
      4'h2:    data_out = r_buf[r_ptr];
      4'h3:    data_out = ui_in;
      default: data_out = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_bit_idx <= '0;
      r_cyc     <= '0;
      r_lat     <= '0;
      r_bit     <= 1'b0;
      r_dout    <= 1'b0;
      r_done    <= 1'b0;
      r_repeat  <= 1'b0;
      r_err     <= 1'b0;
      for (int i = 0; i < NBYTES; i++) begin
        r_buf[i] <= 8'h00;
      end
    end else begin
      if (w_wr_ctrl) begin
        r_repeat <= data_in[2];
        if (data_in[1]) r_done <= 1'b0;
        if (data_in[3]) r_err  <= 1'b0;
      end

      if (w_wr_ptr) begin
        if (data_in >= 8'(NBYTES)) r_ptr <= '0;
        else                       r_ptr <= data_in[PW-1:0];
      end

      // No buffer writes during a frame, so a frame can never show torn data.
      if (w_wr_data) begin
        if (w_busy) begin
          r_err <= 1'b1;
        end else begin
          r_buf[r_ptr] <= data_in;
          r_ptr        <= (r_ptr == PW'(NBYTES - 1)) ? '0 : r_ptr + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          r_dout <= 1'b0;
          if (w_start) begin
            r_state   <= S_SEND;
            r_bit_idx <= '0;
            r_cyc     <= '0;
            r_bit     <= r_buf[0][7];
            r_dout    <= 1'b1;
          end
        end

        S_SEND: begin
          if (w_last_cyc) begin
            r_cyc <= '0;
            if (w_last_bit) begin
              r_state <= S_LATCH;
              r_lat   <= '0;
              r_dout  <= 1'b0;
            end else begin
              r_bit_idx <= w_nxt_idx;
              r_bit     <= w_nxt_bit;
              r_dout    <= 1'b1;
            end
          end else begin
            r_cyc  <= w_cyc_nxt;
            r_dout <= w_high_nxt;
          end
        end

        S_LATCH: begin
          r_dout <= 1'b0;
          if (w_last_lat) begin
            // Placed after the W1C above so a coincident clear loses.
            r_done <= 1'b1;
            if (w_repeat_nxt) begin
              r_state   <= S_SEND;
              r_bit_idx <= '0;
              r_cyc     <= '0;
              r_bit     <= r_buf[0][7];
              r_dout    <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_dout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_strip_driver.sv
// Directed bench for ws2812b_strip_driver with a two-LED chain and default timing.
// Each scenario task drives the register port and checks pin timing and register reads against hand-derived values.
module tb_ws2812b_strip_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  // Pin trace state; g_c is the cycle index relative to the START edge.
  int g_c;
  int g_run;
  int g_busy_end;
  bit g_prev;
  bit g_stray;
  int g_rise[$];
  int g_hi[$];

  ws2812b_strip_driver #(
    .NUM_LEDS(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ui_in     (ui_in),
    .uo_out    (uo_out),
    .address   (address),
    .data_write(data_write),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a;
    #1;
    d = data_out;
  endtask

  task automatic trace_start();
    g_c        = 0;
    g_run      = 0;
    g_prev     = 1'b0;
    g_stray    = 1'b0;
    g_busy_end = -1;
    g_rise.delete();
    g_hi.delete();
  endtask

  task automatic trace(input int n, input bit stop_idle);
    logic d;
    logic b;
    for (int i = 0; i < n; i++) begin
      address = 4'h0;
      #1;
      d = uo_out[1];
      b = data_out[0];
      if ((uo_out & 8'hFD) != 8'h00) g_stray = 1'b1;
      if (d && !g_prev) g_rise.push_back(g_c);
      if (d) g_run++;
      else if (g_prev) begin
        g_hi.push_back(g_run);
        g_run = 0;
      end
      g_prev = d;
      if (!b && g_busy_end < 0) g_busy_end = g_c;
      if (stop_idle && !b) break;
      @(negedge clk);
      g_c++;
    end
  endtask

  task automatic load_buf(input logic [7:0] b0, input logic [7:0] rest);
    wr(4'h1, 8'h00);
    wr(4'h2, b0);
    for (int i = 1; i < 6; i++) wr(4'h2, rest);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0; data_write = 1'b0; address = 4'h0; data_in = 8'h00; ui_in = 8'hA5;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd(4'h0, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", v); end
    rd(4'h2, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", v); end
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out got %h want 00", uo_out); end
    rd(4'h3, v); checks++;
    if (v !== 8'hA5) begin errors++; $display("FAIL read_ui_in got %h want a5", v); end
    rd(4'h1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_ptr got %h want 00", v); end
  endtask

  task automatic test_fill_wrap();
    logic [7:0] v;
    logic [7:0] exp;
    wr(4'h1, 8'h00);
    for (int i = 0; i < 6; i++) wr(4'h2, 8'(17 * (i + 1)));
    rd(4'h1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL ptr_wrap got %h want 00", v); end
    wr(4'h2, 8'h77);
    rd(4'h1, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL ptr_after_7th got %h want 01", v); end
    for (int i = 0; i < 6; i++) begin
      wr(4'h1, 8'(i));
      exp = (i == 0) ? 8'h77 : 8'(17 * (i + 1));
      rd(4'h2, v); checks++;
      if (v !== exp) begin errors++; $display("FAIL readback[%0d] got %h want %h", i, v, exp); end
      rd(4'h1, v); checks++;
      if (v !== 8'(i)) begin errors++; $display("FAIL ptr_no_inc[%0d] got %h want %h", i, v, 8'(i)); end
    end
    wr(4'h1, 8'h06);
    rd(4'h1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL ptr_oob got %h want 00", v); end
    wr(4'h5, 8'h3C);
    rd(4'h5, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL unused_addr got %h want 00", v); end
    rd(4'h2, v); checks++;
    if (v !== 8'h77) begin errors++; $display("FAIL unused_write_buf got %h want 77", v); end
  endtask

  task automatic test_bit_timing();
    logic [7:0] v;
    int bad_t0;
    int bad_per;
    load_buf(8'h80, 8'h00);
    wr(4'h0, 8'h01);
    trace_start();
    trace(8000, 1'b1);
    checks++;
    if (g_busy_end != 7040) begin errors++; $display("FAIL busy_len got %0d want 7040", g_busy_end); end
    checks++;
    if (g_rise.size() != 48 || g_hi.size() != 48) begin
      errors++; $display("FAIL pulse_count got %0d/%0d want 48", g_rise.size(), g_hi.size());
    end else begin
      bad_t0 = 0; bad_per = 0;
      for (int i = 1; i < 48; i++) begin
        if (g_hi[i] != 26) bad_t0++;
        if (g_rise[i] - g_rise[i-1] != 80) bad_per++;
      end
      checks++;
      if (g_rise[0] != 0) begin errors++; $display("FAIL first_high got cycle %0d want 0", g_rise[0]); end
      checks++;
      if (g_hi[0] != 51) begin errors++; $display("FAIL t1h_width got %0d want 51", g_hi[0]); end
      checks++;
      if (bad_t0 != 0) begin errors++; $display("FAIL t0h_width bad pulses %0d want 0", bad_t0); end
      checks++;
      if (bad_per != 0) begin errors++; $display("FAIL bit_period bad periods %0d want 0", bad_per); end
      checks++;
      if (g_busy_end - (g_rise[47] + 80) != 3200) begin
        errors++; $display("FAIL latch_gap got %0d want 3200", g_busy_end - (g_rise[47] + 80));
      end
    end
    checks++;
    if (g_stray) begin errors++; $display("FAIL uo_out_other_bits got nonzero want 0"); end
    rd(4'h0, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL done_set got %h want 02", v); end
    wr(4'h0, 8'h02);
    rd(4'h0, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL done_clear got %h want 00", v); end
  endtask

  task automatic test_busy_protect();
    logic [7:0] v;
    wr(4'h0, 8'h01);
    trace_start();
    wr(4'h1, 8'h03); g_c += 2;
    wr(4'h2, 8'hFF); g_c += 2;
    address = 4'h0; #1; checks++;
    if (data_out !== 8'h09) begin errors++; $display("FAIL err_busy got %h want 09", data_out); end
    wr(4'h0, 8'h01); g_c += 2;
    trace(8000, 1'b1);
    checks++;
    if (g_busy_end != 7040) begin errors++; $display("FAIL busy_frame_len got %0d want 7040", g_busy_end); end
    rd(4'h0, v); checks++;
    if (v !== 8'h0A) begin errors++; $display("FAIL busy_status got %h want 0a", v); end
    rd(4'h1, v); checks++;
    if (v !== 8'h03) begin errors++; $display("FAIL ptr_kept got %h want 03", v); end
    rd(4'h2, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL buf3_kept got %h want 00", v); end
    wr(4'h1, 8'h00);
    rd(4'h2, v); checks++;
    if (v !== 8'h80) begin errors++; $display("FAIL buf0_kept got %h want 80", v); end
    wr(4'h0, 8'h08);
    rd(4'h0, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL err_clear got %h want 02", v); end
    wr(4'h0, 8'h02);
  endtask

  task automatic test_repeat();
    logic [7:0] v;
    int n;
    wr(4'h0, 8'h05);
    trace_start();
    trace(7041, 1'b0);
    address = 4'h0; #1; checks++;
    if (data_out !== 8'h07) begin errors++; $display("FAIL repeat_status got %h want 07", data_out); end
    trace(959, 1'b0);
    checks++;
    if (g_rise.size() < 49) begin
      errors++; $display("FAIL repeat_rises got %0d want >=49", g_rise.size());
    end else begin
      checks++;
      if (g_rise[48] != 7040) begin errors++; $display("FAIL frame2_start got %0d want 7040", g_rise[48]); end
      checks++;
      if (g_rise[48] - g_rise[47] != 3280) begin
        errors++; $display("FAIL frame_gap got %0d want 3280", g_rise[48] - g_rise[47]);
      end
    end
    wr(4'h0, 8'h00); g_c += 2;
    trace(8000, 1'b1);
    checks++;
    if (g_busy_end != 14080) begin errors++; $display("FAIL repeat_stop got %0d want 14080", g_busy_end); end
    rd(4'h0, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL repeat_end_status got %h want 02", v); end
    n = g_rise.size();
    trace(200, 1'b0);
    checks++;
    if (g_rise.size() != n) begin errors++; $display("FAIL no_third_frame got %0d rises want %0d", g_rise.size(), n); end
    wr(4'h0, 8'h02);
  endtask

  task automatic test_done_set_wins();
    logic [7:0] v;
    wr(4'h0, 8'h01);
    repeat (7038) @(negedge clk);
    wr(4'h0, 8'h02);
    rd(4'h0, v); checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL done_set_wins got %h want 02", v); end
    wr(4'h0, 8'h02);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] v;
    int bad;
    load_buf(8'hFF, 8'hFF);
    wr(4'h0, 8'h05);
    repeat (805) @(negedge clk);
    #1; checks++;
    if (uo_out !== 8'h02) begin errors++; $display("FAIL pre_reset_high got %h want 02", uo_out); end
    rst_n = 1'b0;
    @(negedge clk);
    address = 4'h0;
    #1; checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", uo_out); end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_mid_status got %h want 00", data_out); end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      wr(4'h1, 8'(i));
      rd(4'h2, v);
      if (v !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_buf nonzero bytes %0d want 0", bad); end
    repeat (20) @(negedge clk);
    rd(4'h0, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_idle got %h want 00", v); end
  endtask

  initial begin
    test_reset();
    test_fill_wrap();
    test_bit_timing();
    test_busy_protect();
    test_repeat();
    test_done_set_wins();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812b_strip_driver.md
# ws2812b_strip_driver

TinyQV byte peripheral that drives a chain of WS2812B LEDs from an internal colour buffer. Firmware writes GRB bytes through an auto-incrementing data port, then starts a frame. The block serialises the buffer with WS2812B one-wire timing on a PMOD output pin, including the latch gap. A REPEAT mode refreshes the strip continuously without CPU involvement.

## Interface
- NUM_LEDS, 4, LEDs in chain; buffer holds 3*NUM_LEDS bytes
- T0H, 26, high cycles for a 0 bit (0.4 µs at 64 MHz)
- T1H, 51, high cycles for a 1 bit (0.8 µs)
- TBIT, 80, total cycles per bit (1.25 µs); legal only if T0H < T1H < TBIT
- RES_CYCLES, 3200, low latch time after a frame (50 µs)
- OUT_BIT, 1, uo_out bit carrying the serial stream (never 0, which is UART TX)

Ports:
- clk input 1 — project clock, 64 MHz nominal
- rst_n input 1 — reset, synchronous, active-low
- ui_in input 8 — PMOD inputs, readable at address 0x3
- uo_out output 8 — bit OUT_BIT = serial data; all other bits 0
- address input 4 — register select
- data_write input 1 — write strobe, one cycle
- data_in input 8 — write data, valid with data_write
- data_out output 8 — combinational read data for the current address

## Operation
Register map:
- 0x0 CTRL/STATUS
  - Write: bit0 START; bit1 DONE W1C; bit2 REPEAT (stored); bit3 ERR W1C.
  - Read: {4'b0, ERR, REPEAT, DONE, BUSY}.
- 0x1 PTR: write sets the byte pointer; values ≥ 3*NUM_LEDS load 0. Read returns the pointer.
- 0x2 DATA: write stores data_in at buf[PTR] and increments PTR, wrapping from 3*NUM_LEDS-1 to 0. Read returns buf[PTR] without incrementing.
- 0x3 reads ui_in. 0x4–0xF read 0; writes to them are ignored.

Buffer layout: LED i occupies bytes 3i (G), 3i+1 (R), 3i+2 (B). Stream order is byte 0 first, MSB first within each byte.

FSM: IDLE → SEND → LATCH → IDLE.
- IDLE: dout=0. START=1 → SEND with bit index 0 and bit counter 0.
- SEND: each bit lasts TBIT cycles. dout=1 for the first T0H or T1H cycles (for a 0 or 1 bit respectively), then 0. After bit 24*NUM_LEDS-1, go to LATCH.
- LATCH: dout=0 for RES_CYCLES cycles. Then:
  - set DONE;
  - if REPEAT=1, go to SEND directly (new frame, re-reads the buffer);
  - otherwise go to IDLE.
- BUSY = (state != IDLE).

Boundary rules:
- START while BUSY: ignored.
- DATA write while BUSY: dropped, PTR unchanged, ERR set. PTR writes are allowed while BUSY.
- Clearing REPEAT mid-frame: the current frame and its latch complete, then the FSM goes to IDLE.
- Simultaneous set and W1C of DONE (latch end coincides with a clear write): set wins.
- A single CTRL write with START=1 and REPEAT=1 starts a frame and arms repeat.
- Reset mid-frame: on the next edge dout=0, FSM=IDLE, with PTR, CTRL bits and buffer all cleared. No partial-frame recovery.

## Timing
- Reset values: uo_out=0x00, data_out follows address (0x0 reads 0x00), buffer all 0x00, PTR=0.
- START sampled at edge E: BUSY reads 1 after E. dout is 1 for the cycle following E.
- A single frame keeps BUSY=1 for exactly 24*NUM_LEDS*TBIT + RES_CYCLES cycles. DONE sets on the same edge BUSY falls.
- In REPEAT mode, consecutive frames are separated by exactly RES_CYCLES low cycles; there is no idle cycle.
- The buffer byte is sampled at the start of each bit. A DATA write cannot occur during a frame, so no tearing is possible.
- Register writes take effect on the edge they are sampled; reads are combinational with no latency.

## Test plan
- Bench uses NUM_LEDS=2 and default timing unless stated.
- Reset then read: address 0x0 → 0x00, address 0x2 → 0x00, uo_out=0x00. Address 0x3 with ui_in=0xA5 → 0xA5.
- Buffer fill and wrap: write PTR=0, then DATA 0x11..0x66 (six writes) → PTR reads 0. Readback via PTR/DATA returns 0x11..0x66. A seventh write lands at byte 0.
- Bit timing: buffer = 0x80,0,0,0,0,0, START → first high pulse 51 cycles, next 47 pulses 26 cycles each, every period 80 cycles. dout low 3200 cycles after the last bit. BUSY high for 7040 cycles total, then DONE=1; writing 0x02 clears DONE.
- Busy protection: during a frame write DATA=0xFF and START → buffer unchanged, ERR=1, frame length unchanged. Writing 0x08 clears ERR.
- REPEAT: CTRL=0x05 → second frame's first rising edge exactly 3200 cycles after the first frame's last bit ends. Write CTRL=0x00 mid-frame → that frame completes, then BUSY=0.
- Reset mid-frame: assert rst_n low during bit 10 → next cycle dout=0, STATUS=0x00, buffer reads 0x00.
